// File: rtl/imem_resp.sv
// imem_resp: instruction memory with fixed-latency fetch responses and a
// program-load mode. 1024 x 32 words, each with a loaded flag that masks
// never-written words to NOP_WORD.
// Optional: define IMEM_PARITY_EN to store an even-parity bit per word and
// expose par_err alongside inst_valid.
module imem_resp #(
  parameter int unsigned WAIT_STATES = 0,
  parameter logic [31:0] NOP_WORD    = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic [9:0]  addr,
  input  logic        load_en,
  input  logic        load_we,
  input  logic [9:0]  load_addr,
  input  logic [31:0] load_data,
  output logic        busy,
  output logic        inst_valid,
  output logic [31:0] inst
`ifdef IMEM_PARITY_EN
  ,
  output logic        par_err
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2,
    LOAD = 2'd3
  } state_t;

  localparam logic [1:0] WAIT_INIT = (WAIT_STATES == 0) ? 2'd0 : 2'(WAIT_STATES - 1);

  state_t      state_q, state_d;
  logic [9:0]  addr_q, addr_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] mem_q [1024];
  logic [1023:0] flag_q;
  logic [9:0]  fetch_addr;
  logic        rd_en;
  logic        wr_en;

`ifdef IMEM_PARITY_EN
  logic        par_q [1024];
  logic        par_err_q, par_err_d;
`endif

  // In IDLE the fetch address comes straight from the port so a zero-wait
  // fetch can read memory on the accepting edge.
  assign fetch_addr = (state_q == IDLE) ? addr : addr_q;
  assign wr_en      = (state_q == LOAD) && load_we;

  // Next-state, wait counter and response word selection
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    inst_d  = inst_q;
    rd_en   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (load_en) begin
          state_d = LOAD;
        end else if (req) begin
          addr_d = addr;
          if (WAIT_STATES == 0) begin
            state_d = RESP;
            rd_en   = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = WAIT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 2'd0) begin
          state_d = RESP;
          rd_en   = 1'b1;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      LOAD: begin
        if (!load_en) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (rd_en) begin
      inst_d = flag_q[fetch_addr] ? mem_q[fetch_addr] : NOP_WORD;
    end
  end

`ifdef IMEM_PARITY_EN
  // Parity check happens on the same edge that captures the response word
  always_comb begin
    par_err_d = 1'b0;
    if (rd_en && flag_q[fetch_addr]) begin
      par_err_d = (^mem_q[fetch_addr]) != par_q[fetch_addr];
    end
  end
`endif

  // Control state, latched address, counter, response word and loaded flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      inst_q  <= '0;
      flag_q  <= '0;
`ifdef IMEM_PARITY_EN
      par_err_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      inst_q  <= inst_d;
      if (wr_en) flag_q[load_addr] <= 1'b1;
`ifdef IMEM_PARITY_EN
      par_err_q <= par_err_d;
`endif
    end
  end

  // Word storage; contents survive reset because the flags mask them
  always_ff @(posedge clk) begin
    if (!rst && wr_en) begin
      mem_q[load_addr] <= load_data;
`ifdef IMEM_PARITY_EN
      par_q[load_addr] <= ^load_data;
`endif
    end
  end

  assign busy       = (state_q != IDLE);
  assign inst_valid = (state_q == RESP);
  assign inst       = inst_q;
`ifdef IMEM_PARITY_EN
  assign par_err    = par_err_q;
`endif

endmodule
